// File: rtl/axi_axis_reader_pkg.sv
// Shared constants and types for the stream reader arbiter.
package axi_axis_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam int         ADDR_SEL_BIT = 2;
  localparam int         EMPTY_CNT_W  = 16;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [EMPTY_CNT_W-1:0] sat_inc(input logic [EMPTY_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_axis_reader_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to the port that did not win last.
module rr_arbiter2
  import axi_axis_reader_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  // One-hot grant from the current requests and the previous winner.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember the winner; reset value 1 makes port 0 win the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/axi_axis_reader_arbiter.sv
// Shares one AXI4-Stream source between two AXI4-Lite read-only ports.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for an address; the arbiter grants one port
// ST_RESP | rvalid held on the selected port until its rready
module axi_axis_reader_arbiter
  import axi_axis_reader_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_sel;
  logic [AXI_DATA_WIDTH-1:0] r_rdata0;
  logic [AXI_DATA_WIDTH-1:0] r_rdata1;
  logic [EMPTY_CNT_W-1:0]    r_empty_cnt;

  logic                      w_idle;
  logic [1:0]                w_req;
  logic [1:0]                w_grant;
  logic                      w_hs;
  logic                      w_hs_port;
  logic                      w_status_rd;
  logic                      w_empty_rd;
  logic                      w_rready_sel;
  logic [AXI_DATA_WIDTH-1:0] w_status_word;
  logic [AXI_DATA_WIDTH-1:0] w_capture;
  logic                      w_unused_addr;

  // Gating with aresetn keeps arready and tready low while reset is held.
  assign w_idle = (r_state == ST_IDLE) && aresetn;
  assign w_req  = w_idle ? {s1_axi_arvalid, s0_axi_arvalid} : 2'b00;

  rr_arbiter2 u_arb (
    .i_clk    (aclk),
    .i_rst_n  (aresetn),
    .i_req    (w_req),
    .i_update (w_hs),
    .o_grant  (w_grant)
  );

  // A grant is only issued to a requesting port, so grant == handshake.
  assign w_hs        = |w_grant;
  assign w_hs_port   = w_grant[1];
  assign w_status_rd = w_hs_port ? s1_axi_araddr[ADDR_SEL_BIT] : s0_axi_araddr[ADDR_SEL_BIT];
  assign w_empty_rd  = w_hs && !w_status_rd && !s_axis_tvalid;

  // Only one address bit is decoded; the rest are deliberately ignored.
  assign w_unused_addr = ^{s0_axi_araddr, s1_axi_araddr};

  assign s0_axi_arready = w_grant[0];
  assign s1_axi_arready = w_grant[1];
  assign s_axis_tready  = w_hs && !w_status_rd && s_axis_tvalid;

  // Status word: empty-read count in the upper half, live tvalid in bit 0.
  always_comb begin
    w_status_word        = '0;
    w_status_word[31:16] = r_empty_cnt;
    w_status_word[0]     = s_axis_tvalid;
  end

  assign w_capture = w_status_rd   ? w_status_word :
                     s_axis_tvalid ? s_axis_tdata  : '0;

  assign w_rready_sel = r_sel ? s1_axi_rready : s0_axi_rready;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_hs)         w_state_nxt = ST_RESP;
      ST_RESP: if (w_rready_sel) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the selected port and its read data at the address handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sel    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_hs) begin
      r_sel <= w_hs_port;
      if (w_hs_port) r_rdata1 <= w_capture;
      else           r_rdata0 <= w_capture;
    end
  end

  // Count data reads that found the stream empty.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_empty_cnt <= '0;
    end else if (w_empty_rd) begin
      r_empty_cnt <= sat_inc(r_empty_cnt);
    end
  end

  // rvalid derives from state so reset drops it without waiting for a clock.
  assign s0_axi_rvalid = (r_state == ST_RESP) && !r_sel;
  assign s1_axi_rvalid = (r_state == ST_RESP) &&  r_sel;
  assign s0_axi_rdata  = r_rdata0;
  assign s1_axi_rdata  = r_rdata1;
  assign s0_axi_rresp  = RESP_OKAY;
  assign s1_axi_rresp  = RESP_OKAY;

endmodule
